// File: rtl/patterns_pkg.sv
// Shared encodings for the pattern-datapath sample generators.
// Mode and step-select codes are common to ramp_gen and its siblings.
package patterns_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP = 2'b00,
        MODE_SAT  = 2'b01,
        MODE_TRI  = 2'b10,
        MODE_HOLD = 2'b11
    } ramp_mode_e;

    typedef enum logic [1:0] {
        Y0    = 2'b00,
        Y1    = 2'b01,
        Y16   = 2'b10,
        Y1290 = 2'b11
    } step_sel_e;

endpackage

// File: rtl/ramp_step_lut.sv
// Combinational step-select decode: maps a 2-bit select onto one of four
// per-instance step constants.
module ramp_step_lut
    import patterns_pkg::*;
#(
    parameter int          STEP_W = 11,
    parameter int unsigned STEP0  = 0,
    parameter int unsigned STEP1  = 1,
    parameter int unsigned STEP2  = 16,
    parameter int unsigned STEP3  = 1290
) (
    input  logic [1:0]        y_i,
    output logic [STEP_W-1:0] step_o
);

    always_comb begin
        step_o = '0;
        case (step_sel_e'(y_i))
            Y0:    step_o = STEP_W'(STEP0);
            Y1:    step_o = STEP_W'(STEP1);
            Y16:   step_o = STEP_W'(STEP2);
            Y1290: step_o = STEP_W'(STEP3);
            default: step_o = '0;
        endcase
    end

endmodule

// File: rtl/ramp_gen.sv
// Ramp sample generator: advances out by a selected step on each rising edge
// of delta, with wrap, saturate, triangle-bounce and hold behaviours.
module ramp_gen
    import patterns_pkg::*;
#(
    parameter int          WIDTH   = 12,
    parameter int unsigned MAX_VAL = 4095,
    parameter int          STEP_W  = 11,
    parameter int unsigned STEP0   = 0,
    parameter int unsigned STEP1   = 1,
    parameter int unsigned STEP2   = 16,
    parameter int unsigned STEP3   = 1290
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ramp_enb,
    input  logic             delta,
    input  logic [1:0]       Y,
    input  logic [1:0]       mode,
    output logic [WIDTH-1:0] out,
    output logic             dir,
    output logic             wrap_pulse,
    output logic             sat
);

    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_VAL);
    localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] MAX_P1  = WIDTH'(MAX_VAL + 1);

    logic [WIDTH-1:0] out_q, out_d;
    logic             dir_q, dir_d;
    logic             sat_q, sat_d;
    logic             wrap_q, wrap_d;
    logic             delta_q;

    logic [STEP_W-1:0] step_raw;
    logic [WIDTH-1:0]  step_w;
    logic [WIDTH:0]    sum_ext;
    logic              over;
    logic              step_ev;
    logic              dir_eff;
    ramp_mode_e        mode_s;

    ramp_step_lut #(
        .STEP_W (STEP_W),
        .STEP0  (STEP0),
        .STEP1  (STEP1),
        .STEP2  (STEP2),
        .STEP3  (STEP3)
    ) u_step_lut (
        .y_i    (Y),
        .step_o (step_raw)
    );

    assign mode_s  = ramp_mode_e'(mode);
    assign step_w  = WIDTH'(step_raw);
    assign step_ev = delta & ~delta_q;
    // The carry bit is kept only for the overflow decision; every result
    // that is actually stored fits in WIDTH bits, so it is formed modulo 2^WIDTH.
    assign sum_ext = {1'b0, out_q} + {1'b0, step_w};
    assign over    = (sum_ext > MAX_EXT);
    // A stale down-direction left over from triangle mode is discarded here.
    assign dir_eff = (mode_s == MODE_TRI) ? dir_q : 1'b1;

    always_comb begin
        out_d  = out_q;
        dir_d  = dir_q;
        sat_d  = sat_q;
        wrap_d = 1'b0;
        if (!ramp_enb) begin
            out_d = '0;
            dir_d = 1'b1;
            sat_d = 1'b0;
        end else if (step_ev && (mode_s != MODE_HOLD)) begin
            dir_d = dir_eff;
            case (mode_s)
                MODE_WRAP: begin
                    if (over) begin
                        out_d  = out_q + step_w - MAX_P1;
                        wrap_d = 1'b1;
                    end else begin
                        out_d = out_q + step_w;
                    end
                end
                MODE_SAT: begin
                    if (over) begin
                        out_d = MAX_W;
                        sat_d = 1'b1;
                    end else begin
                        out_d = out_q + step_w;
                    end
                end
                MODE_TRI: begin
                    if (dir_eff) begin
                        if (over) begin
                            out_d  = MAX_W - (out_q + step_w - MAX_W);
                            dir_d  = 1'b0;
                            wrap_d = 1'b1;
                        end else begin
                            out_d = out_q + step_w;
                        end
                    end else if (out_q < step_w) begin
                        out_d  = step_w - out_q;
                        dir_d  = 1'b1;
                        wrap_d = 1'b1;
                    end else begin
                        out_d = out_q - step_w;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '0;
            dir_q   <= 1'b1;
            sat_q   <= 1'b0;
            wrap_q  <= 1'b0;
            delta_q <= 1'b0;
        end else begin
            out_q   <= out_d;
            dir_q   <= dir_d;
            sat_q   <= sat_d;
            wrap_q  <= wrap_d;
            delta_q <= delta;
        end
    end

    assign out        = out_q;
    assign dir        = dir_q;
    assign sat        = sat_q;
    assign wrap_pulse = wrap_q;

endmodule
